// File: rtl/uart_frame_decoder.sv
// UART frame decoder: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Result registered one clk after the last stop strobe; no backpressure, strobes accepted on any cycle.
module uart_frame_decoder #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TIMEOUT   = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  localparam int BC_W = $clog2(DATA_BITS);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_BITS - 1);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_mis_q, par_mis_d;
  logic                 stop_err_q, stop_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic                 in_frame;
  logic                 wd_expire;

  always_comb begin
    in_frame  = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
    // A strobe arriving on the expiry cycle keeps the frame alive.
    wd_expire = in_frame && !bit_valid_i && (wd_q == WD_LIMIT);

    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    par_acc_d    = par_acc_q;
    par_mis_d    = par_mis_q;
    stop_err_d   = stop_err_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    timeout_d    = 1'b0;
    wd_d         = (in_frame && !bit_valid_i) ? wd_q + WD_W'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (bit_valid_i && !bit_i) begin
          state_d    = S_DATA;
          shift_d    = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_acc_d  = 1'b0;
          par_mis_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_valid_i) begin
          shift_d   = {bit_i, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ bit_i;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_valid_i) begin
          par_mis_d = par_acc_q ^ bit_i ^ (PARITY == 2);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_valid_i) begin
          if (stop_cnt_q == LAST_STOP) begin
            data_valid_d = 1'b1;
            data_d       = shift_q;
            frame_err_d  = stop_err_q | !bit_i;
            parity_err_d = (PARITY != 0) && par_mis_q;
            stop_cnt_d   = 1'b0;
            stop_err_d   = 1'b0;
            // A low final stop means the line is held low; wait for it to release.
            state_d      = bit_i ? S_IDLE : S_BREAK;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            stop_err_d = stop_err_q | !bit_i;
          end
        end
      end
      S_BREAK: begin
        if (bit_valid_i && bit_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wd_expire) begin
      data_valid_d = 1'b1;
      data_d       = shift_q;
      frame_err_d  = 1'b1;
      parity_err_d = 1'b0;
      timeout_d    = 1'b1;
      bit_cnt_d    = '0;
      stop_cnt_d   = 1'b0;
      state_d      = S_IDLE;
    end

    busy_d = (state_d == S_DATA) || (state_d == S_PARITY) || (state_d == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      wd_q         <= '0;
      par_acc_q    <= 1'b0;
      par_mis_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      wd_q         <= wd_d;
      par_acc_q    <= par_acc_d;
      par_mis_q    <= par_mis_d;
      stop_err_q   <= stop_err_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: three instances (no parity / even parity / odd parity + two stops)
// share one bit stream; each scenario resets them and checks the instance it targets.
module tb_uart_frame_decoder;

  typedef struct packed {
    logic [7:0]  data;
    logic        fe;
    logic        pe;
    logic        to;
    logic [31:0] cyc;
  } rec_t;

  localparam int TMO = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_i = 1'b1;
  logic       bit_valid_i = 1'b0;
  logic [7:0] data [3];
  logic [2:0] dv, fe, pe, to, busy;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int          viol_cnt = 0;
  logic [2:0]  prev_dv = 3'b000;
  int          par_mode [3] = '{0, 1, 2};
  int          nstop [3] = '{1, 1, 2};
  rec_t        obs0[$], obs1[$], obs2[$];

  always #5 clk = ~clk;

  uart_frame_decoder u_d0 (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .data_o(data[0]), .data_valid_o(dv[0]), .frame_err_o(fe[0]),
    .parity_err_o(pe[0]), .timeout_o(to[0]), .busy_o(busy[0])
  );
  uart_frame_decoder #(.PARITY(1)) u_d1 (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .data_o(data[1]), .data_valid_o(dv[1]), .frame_err_o(fe[1]),
    .parity_err_o(pe[1]), .timeout_o(to[1]), .busy_o(busy[1])
  );
  uart_frame_decoder #(.PARITY(2), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .data_o(data[2]), .data_valid_o(dv[2]), .frame_err_o(fe[2]),
    .parity_err_o(pe[2]), .timeout_o(to[2]), .busy_o(busy[2])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with the cycle it appeared in.
  always @(negedge clk) begin
    if (!rst) begin
      if (dv[0]) obs0.push_back(rec_t'({data[0], fe[0], pe[0], to[0], cyc}));
      if (dv[1]) obs1.push_back(rec_t'({data[1], fe[1], pe[1], to[1], cyc}));
      if (dv[2]) obs2.push_back(rec_t'({data[2], fe[2], pe[2], to[2], cyc}));
    end
  end

  // Pulses on consecutive cycles or flags outside a pulse are protocol violations.
  always @(negedge clk) begin
    prev_dv <= dv;
    if (!rst && (((dv & prev_dv) != 3'b000) || (((fe | pe | to) & ~dv) != 3'b000)))
      viol_cnt <= viol_cnt + 1;
  end

  function automatic int obs_n(input int k);
    case (k)
      0:       return obs0.size();
      1:       return obs1.size();
      default: return obs2.size();
    endcase
  endfunction

  function automatic rec_t obs_at(input int k, input int i);
    case (k)
      0:       return obs0[i];
      1:       return obs1[i];
      default: return obs2[i];
    endcase
  endfunction

  // Reference: expected result of one complete frame from the framing rules.
  function automatic rec_t model_frame(input int k, input logic [7:0] d, input logic pbit,
                                       input logic [1:0] st, input int unsigned c);
    rec_t r;
    r.data = d;
    r.pe   = (par_mode[k] == 0) ? 1'b0 : (((^d) ^ pbit) != (par_mode[k] == 2));
    r.fe   = (nstop[k] == 1) ? ~st[0] : ~(st[0] & st[1]);
    r.to   = 1'b0;
    r.cyc  = c;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_valid_i = 1'b0;
    bit_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic b, input int gap);
    bit_i = b;
    bit_valid_i = 1'b1;
    last_cyc = cyc + 1;
    @(negedge clk);
    bit_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit,
                            input logic [1:0] st, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
    if (par_mode[k] != 0) strobe(pbit, gap);
    strobe(st[0], gap);
    if (nstop[k] == 2) strobe(st[1], gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({data[k], dv[k], fe[k], pe[k], to[k], busy[k]} !== 13'b0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d got=%h exp=0", k,
                 {data[k], dv[k], fe[k], pe[k], to[k], busy[k]});
      end
    end
    rst = 1'b0;
    repeat (10) strobe(1'b1, 1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs_n(k) !== 0 || busy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_line dut%0d got pulses=%0d busy=%b exp pulses=0 busy=0", k, obs_n(k), busy[k]);
      end
    end
  endtask

  task automatic test_basic();
    int base;
    rec_t got, want;
    logic [7:0] d;
    d = 8'hA5;
    do_reset();
    base = obs_n(0);
    strobe(1'b0, 15);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_start got=%b exp=1", busy[0]);
    end
    for (int i = 0; i < 8; i++) strobe(d[i], 15);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++; $display("FAIL basic_busy_before_stop got=%b exp=1", busy[0]);
    end
    bit_i = 1'b1;
    bit_valid_i = 1'b1;
    last_cyc = cyc + 1;
    @(negedge clk);
    bit_valid_i = 1'b0;
    vectors++;
    if (dv[0] !== 1'b1 || busy[0] !== 1'b0) begin
      miscompares++; $display("FAIL basic_stop_edge got dv=%b busy=%b exp dv=1 busy=0", dv[0], busy[0]);
    end
    @(negedge clk);
    vectors++;
    if (dv[0] !== 1'b0) begin
      miscompares++; $display("FAIL basic_single_pulse got=%b exp=0", dv[0]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_n(0) - base !== 1) begin
      miscompares++; $display("FAIL basic_count got=%0d exp=1", obs_n(0) - base);
    end else begin
      got = obs_at(0, base);
      want = model_frame(0, d, 1'b0, 2'b11, last_cyc);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL basic_frame got=%h exp=%h", got, want);
      end
    end
  endtask

  task automatic test_parity();
    int base;
    int unsigned c1, c2;
    rec_t got, want;
    do_reset();
    base = obs_n(1);
    send_frame(1, 8'h03, 1'b1, 2'b11, 4);
    c1 = last_cyc;
    send_frame(1, 8'h03, 1'b0, 2'b11, 4);
    c2 = last_cyc;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_n(1) - base !== 2) begin
      miscompares++; $display("FAIL parity_count got=%0d exp=2", obs_n(1) - base);
    end else begin
      got = obs_at(1, base);
      want = model_frame(1, 8'h03, 1'b1, 2'b11, c1);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL parity_bad got=%h exp=%h", got, want);
      end
      got = obs_at(1, base + 1);
      want = model_frame(1, 8'h03, 1'b0, 2'b11, c2);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL parity_good got=%h exp=%h", got, want);
      end
    end
  endtask

  task automatic test_break();
    int base;
    int unsigned c1, c2;
    rec_t got, want;
    do_reset();
    base = obs_n(0);
    send_frame(0, 8'h55, 1'b0, 2'b00, 3);
    c1 = last_cyc;
    repeat (20) strobe(1'b0, 3);
    vectors++;
    if (obs_n(0) - base !== 1 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL break_hold got pulses=%0d busy=%b exp pulses=1 busy=0", obs_n(0) - base, busy[0]);
    end
    strobe(1'b1, 3);
    send_frame(0, 8'h12, 1'b0, 2'b11, 3);
    c2 = last_cyc;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_n(0) - base !== 2) begin
      miscompares++; $display("FAIL break_count got=%0d exp=2", obs_n(0) - base);
    end else begin
      got = obs_at(0, base);
      want = model_frame(0, 8'h55, 1'b0, 2'b00, c1);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL break_bad_stop got=%h exp=%h", got, want);
      end
      got = obs_at(0, base + 1);
      want = model_frame(0, 8'h12, 1'b0, 2'b11, c2);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL break_recover got=%h exp=%h", got, want);
      end
    end
  endtask

  task automatic test_timeout();
    int base;
    int unsigned t, c2;
    logic [2:0] b;
    rec_t got, want;
    b = 3'($urandom());
    do_reset();
    base = obs_n(0);
    strobe(1'b0, 3);
    for (int i = 0; i < 3; i++) strobe(b[i], (i == 2) ? 0 : 3);
    t = last_cyc;
    repeat (60) @(negedge clk);
    vectors++;
    if (obs_n(0) - base !== 1 || busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_count got pulses=%0d busy=%b exp pulses=1 busy=0", obs_n(0) - base, busy[0]);
    end else begin
      got = obs_at(0, base);
      want = {8'(b) << 5, 1'b1, 1'b0, 1'b1, 32'(t + TMO)};
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL timeout_abort got=%h exp=%h", got, want);
      end
    end
    send_frame(0, 8'h7E, 1'b0, 2'b11, 2);
    c2 = last_cyc;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_n(0) - base !== 2) begin
      miscompares++; $display("FAIL timeout_next_count got=%0d exp=2", obs_n(0) - base);
    end else begin
      got = obs_at(0, base + 1);
      want = model_frame(0, 8'h7E, 1'b0, 2'b11, c2);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL timeout_next_frame got=%h exp=%h", got, want);
      end
    end
  endtask

  task automatic test_wd_boundary();
    int base;
    int unsigned c1, t;
    logic [1:0] b;
    rec_t got, want;
    b = 2'($urandom());
    do_reset();
    base = obs_n(0);
    send_frame(0, 8'h3C, 1'b0, 2'b11, TMO - 1);
    c1 = last_cyc;
    strobe(1'b0, 3);
    strobe(b[0], 3);
    strobe(b[1], TMO);
    t = last_cyc;
    strobe(1'b1, 3);
    vectors++;
    if (obs_n(0) - base !== 2) begin
      miscompares++; $display("FAIL wd_boundary_count got=%0d exp=2", obs_n(0) - base);
    end else begin
      got = obs_at(0, base);
      want = model_frame(0, 8'h3C, 1'b0, 2'b11, c1);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL wd_last_cycle_strobe got=%h exp=%h", got, want);
      end
      got = obs_at(0, base + 1);
      want = {8'(b) << 6, 1'b1, 1'b0, 1'b1, 32'(t + TMO)};
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL wd_expire got=%h exp=%h", got, want);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    int unsigned c1, c2;
    rec_t got, want;
    do_reset();
    base = obs_n(0);
    send_frame(0, 8'h99, 1'b0, 2'b11, 2);
    c1 = last_cyc;
    strobe(1'b0, 2);
    for (int i = 0; i < 5; i++) strobe(1'($urandom()), 2);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({data[0], dv[0], fe[0], pe[0], to[0], busy[0]} !== 13'b0) begin
      miscompares++;
      $display("FAIL midframe_reset got=%h exp=0", {data[0], dv[0], fe[0], pe[0], to[0], busy[0]});
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    send_frame(0, 8'hC3, 1'b0, 2'b11, 2);
    c2 = last_cyc;
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_n(0) - base !== 2) begin
      miscompares++; $display("FAIL midframe_count got=%0d exp=2", obs_n(0) - base);
    end else begin
      got = obs_at(0, base);
      want = model_frame(0, 8'h99, 1'b0, 2'b11, c1);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL midframe_before got=%h exp=%h", got, want);
      end
      got = obs_at(0, base + 1);
      want = model_frame(0, 8'hC3, 1'b0, 2'b11, c2);
      vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL midframe_after got=%h exp=%h", got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] d [5];
    logic [1:0] st [5];
    int unsigned c [5];
    rec_t got, want;
    d  = '{8'h00, 8'hFF, 8'h5A, 8'hA6, 8'h81};
    st = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b11};
    do_reset();
    base = obs_n(2);
    for (int i = 0; i < 5; i++) begin
      send_frame(2, d[i], ~(^d[i]), st[i], 0);
      c[i] = last_cyc;
      if (st[i][1] == 1'b0) strobe(1'b1, 0);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (obs_n(2) - base !== 5) begin
      miscompares++; $display("FAIL b2b_count got=%0d exp=5", obs_n(2) - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        got = obs_at(2, base + i);
        want = model_frame(2, d[i], ~(^d[i]), st[i], c[i]);
        vectors++;
        if (got !== want) begin
          miscompares++; $display("FAIL b2b_frame%0d got=%h exp=%h", i, got, want);
        end
      end
    end
  endtask

  task automatic test_random();
    rec_t want_q[$];
    rec_t got;
    logic [7:0] d;
    logic pbit, fin;
    logic [1:0] st;
    int gap, base;
    for (int k = 0; k < 3; k++) begin
      want_q.delete();
      do_reset();
      base = obs_n(k);
      for (int n = 0; n < 12; n++) begin
        d = 8'($urandom());
        pbit = 1'($urandom());
        st = {1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0)};
        gap = int'($urandom_range(10, 0));
        send_frame(k, d, pbit, st, gap);
        want_q.push_back(model_frame(k, d, pbit, st, last_cyc));
        fin = (nstop[k] == 2) ? st[1] : st[0];
        if (!fin) begin
          repeat (int'($urandom_range(4, 0))) strobe(1'b0, gap);
          strobe(1'b1, gap);
        end
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (obs_n(k) - base !== want_q.size()) begin
        miscompares++;
        $display("FAIL random_count dut%0d got=%0d exp=%0d", k, obs_n(k) - base, want_q.size());
      end else begin
        for (int i = 0; i < want_q.size(); i++) begin
          got = obs_at(k, base + i);
          vectors++;
          if (got !== want_q[i]) begin
            miscompares++; $display("FAIL random dut%0d frame%0d got=%h exp=%h", k, i, got, want_q[i]);
          end
        end
      end
    end
    vectors++;
    if (viol_cnt !== 0) begin
      miscompares++; $display("FAIL pulse_protocol got violations=%0d exp=0", viol_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_timeout();
    test_wd_boundary();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
Consumes the recovered-bit stream (one bit plus a one-cycle valid strobe per bit period) from the oversampling bit-recovery stage. Assembles UART frames: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits. Presents each received byte with a one-cycle strobe and per-frame error flags to the RX FIFO / host interface. A watchdog aborts frames stalled by dropped bits, such as when line glitches suppress a bit strobe.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
TIMEOUT, 48, clk cycles allowed between bit strobes mid-frame before abort; must be >= 2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
bit_i  in  1  recovered bit value; qualified by bit_valid_i.
bit_valid_i  in  1  one-cycle strobe, one per recovered bit period.
data_o  out  DATA_BITS  received data; held stable between strobes.
data_valid_o  out  1  one-cycle strobe; data_o, frame_err_o, parity_err_o and timeout_o are valid when high.
frame_err_o  out  1  a stop bit was 0, or the frame timed out.
parity_err_o  out  1  parity mismatch; always 0 when PARITY = 0.
timeout_o  out  1  frame aborted by watchdog.
busy_o  out  1  high in DATA, PARITY and STOP states.

Behaviour:
- Interface: clock clk; reset rst, synchronous, active-high.
- Reset values:
  - state = IDLE.
  - data_o = 0; data_valid_o = 0; all error flags = 0; busy_o = 0.
  - Shift register, bit counter, stop counter and watchdog all 0.
- Reset mid-frame discards the partial frame. No strobe is produced.
- bit_valid_i is accepted on any cycle, including back-to-back cycles. The block must not depend on strobe spacing.
- States and transitions:
  - IDLE:
    - bit_valid_i && bit_i == 0 -> DATA. Clear shift register, bit counter and parity accumulator.
    - bit_valid_i && bit_i == 1 -> stay in IDLE (idle line).
  - DATA:
    - Each strobe: shift right, new bit enters the MSB (LSB-first line order); XOR the bit into the parity accumulator; bit counter +1.
    - On the strobe carrying bit DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
  - PARITY:
    - On the strobe, latch the mismatch. Even: accumulator ^ bit must be 0. Odd: it must be 1.
    - -> STOP.
  - STOP:
    - Each strobe: if bit_i == 0, set the sticky stop-error flag.
    - On the STOP_BITS-th stop strobe, complete the frame:
      - Next cycle: data_valid_o = 1, data_o = shift register, frame_err_o = sticky stop-error, parity_err_o = latched mismatch, timeout_o = 0.
      - If the final stop bit was 0 -> BREAK, else -> IDLE.
  - BREAK:
    - Ignore 0 bits.
    - First strobe with bit_i == 1 -> IDLE. This prevents a held-low line from being decoded as repeated start bits.
- Latency: data_valid_o rises exactly one clk after the cycle in which the last stop strobe is sampled (registered output).
- Watchdog:
  - Counts clk cycles while in DATA, PARITY or STOP; cleared on every bit_valid_i.
  - If it reaches TIMEOUT-1 on a cycle with no bit_valid_i:
    - Next cycle: data_valid_o = 1, frame_err_o = 1, timeout_o = 1, parity_err_o = 0, data_o = current shift register contents (partial frame).
    - state -> IDLE.
  - If bit_valid_i and timeout occur in the same cycle, bit_valid_i wins and the counter clears.
  - Counter is held at 0 in IDLE and BREAK. Width is clog2(TIMEOUT).
- data_valid_o is never high on two consecutive cycles.
- Error flags are meaningful only while data_valid_o = 1; they are driven 0 otherwise.

Test Plan:
1. Defaults; strobes every 16 cycles with bits 0, 1,0,1,0,0,1,0,1, 1 (start, 0xA5 LSB first, stop) -> one data_valid_o pulse one cycle after the stop strobe; data_o = 0xA5; all error flags 0; busy_o high from the start strobe to the stop strobe.
2. PARITY = 1; send 0x03 with parity bit 1 -> data_o = 0x03, parity_err_o = 1, frame_err_o = 0. Repeat with parity bit 0 -> parity_err_o = 0.
3. Send 0x55 with stop bit 0, then 20 more 0 strobes, then one 1 strobe, then frame 0x12 -> first strobe shows frame_err_o = 1; no strobes during the 0 run; the next strobe shows data_o = 0x12 with no errors.
4. Start bit plus 3 data bits, then no strobes for 60 cycles -> at cycle TIMEOUT after the last strobe: data_valid_o = 1, frame_err_o = 1, timeout_o = 1; state returns to IDLE; a following 0x7E frame decodes cleanly.
5. rst asserted for one cycle after 5 data bits -> no data_valid_o pulse; all outputs 0; busy_o = 0; the next frame 0xC3 decodes cleanly.
6. STOP_BITS = 2; back-to-back frames 0x00 and 0xFF with bit_valid_i on consecutive clk cycles -> two pulses, data_o = 0x00 then 0xFF, no errors; a 0 in the second stop bit sets frame_err_o.
